// File: rtl/execute_alu_pkg.sv
// execute_alu_pkg: shared types and constants for the execute-stage ALU.
//   alu_ctrl_t    : 2-bit operation code from decode (ADD, SUB, MUL, PASSA)
//   state_t       : top-level FSM encoding (IDLE, MUL_BUSY)
//   DEFAULT_WIDTH : default datapath width
//   MUL_CNT_W     : width of the multiplier latency counter (covers 0..15)
package execute_alu_pkg;

   localparam int DEFAULT_WIDTH = 32;
   localparam int MUL_CNT_W     = 4;

   typedef enum logic [1:0] {
      ALU_ADD   = 2'b00,
      ALU_SUB   = 2'b01,
      ALU_MUL   = 2'b10,
      ALU_PASSA = 2'b11
   } alu_ctrl_t;

   typedef enum logic {
      ST_IDLE     = 1'b0,
      ST_MUL_BUSY = 1'b1
   } state_t;

endpackage

// File: rtl/execute_alu_if.sv
// execute_alu_if: handshake bundle between decode, the ALU and the memory stage.
//   master modport : decode/downstream side (drives operations and out_ready)
//   slave modport  : ALU side (drives in_ready, result, tag, busy, dbg_state)
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high. A producer holds valid and its payload stable until the transfer; ready
// never depends on valid in the same cycle.
interface execute_alu_if
   import execute_alu_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
);
   logic             in_valid;
   logic             in_ready;
   logic [1:0]       alu_ctrl;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic [4:0]       dst_reg;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic [4:0]       out_dst_reg;
   logic             busy;
   state_t           dbg_state;

   modport master (
      output in_valid, alu_ctrl, op_a, op_b, dst_reg, out_ready,
      input  in_ready, out_valid, result, out_dst_reg, busy, dbg_state
   );

   modport slave (
      input  in_valid, alu_ctrl, op_a, op_b, dst_reg, out_ready,
      output in_ready, out_valid, result, out_dst_reg, busy, dbg_state
   );
endinterface

// File: rtl/alu_mul_unit.sv
// alu_mul_unit: multi-cycle multiplier slice of the execute ALU.
//   start       : operation accepted this edge; capture operands, tag, load counter
//   active      : top FSM is in MUL_BUSY; counter decrements while nonzero
//   a, b, dst   : operands and destination tag
//   done        : counter reached zero while active; product is ready to load
//   product     : low WIDTH bits of the unsigned product
//   product_dst : tag captured with the operands
module alu_mul_unit
   import execute_alu_pkg::*;
#(
   parameter int WIDTH       = DEFAULT_WIDTH,
   parameter int MUL_LATENCY = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             active,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [4:0]       dst,
   output logic             done,
   output logic [WIDTH-1:0] product,
   output logic [4:0]       product_dst
);
   localparam logic [MUL_CNT_W-1:0] CNT_LOAD = MUL_CNT_W'(MUL_LATENCY - 1);

   logic [WIDTH-1:0]     a_q, a_d, b_q, b_d, prod_q, prod_d;
   logic [4:0]           dst_q, dst_d;
   logic [MUL_CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      a_d    = a_q;
      b_d    = b_q;
      dst_d  = dst_q;
      cnt_d  = cnt_q;
      // Product register trails the operand registers by one edge; with a
      // minimum latency of 2 it is settled before the counter expires.
      prod_d = a_q * b_q;
      if (start) begin
         a_d   = a;
         b_d   = b;
         dst_d = dst;
         cnt_d = CNT_LOAD;
      end else if (active && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         a_q    <= '0;
         b_q    <= '0;
         dst_q  <= '0;
         cnt_q  <= '0;
         prod_q <= '0;
      end else begin
         a_q    <= a_d;
         b_q    <= b_d;
         dst_q  <= dst_d;
         cnt_q  <= cnt_d;
         prod_q <= prod_d;
      end
   end

   assign done        = active && (cnt_q == '0);
   assign product     = prod_q;
   assign product_dst = dst_q;
endmodule

// File: rtl/execute_alu.sv
// execute_alu: execute-stage ALU with a one-entry registered output.
//   clk, reset : rising-edge clock, synchronous active-high reset
//   bus        : execute_alu_if slave modport (operation in, result out, busy)
// ADD/SUB/PASSA complete in one cycle at full throughput; MUL occupies the
// block for MUL_LATENCY cycles in MUL_BUSY, during which nothing is accepted.
module execute_alu
   import execute_alu_pkg::*;
#(
   parameter int WIDTH       = DEFAULT_WIDTH,
   parameter int MUL_LATENCY = 5
) (
   input  logic         clk,
   input  logic         reset,
   execute_alu_if.slave bus
);
   state_t           state_q, state_d;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic [4:0]       out_dst_q, out_dst_d;

   logic             in_ready;
   logic             accept;
   logic             mul_start;
   logic             mul_done;
   logic [WIDTH-1:0] mul_product;
   logic [4:0]       mul_dst;
   logic [WIDTH-1:0] alu_res;
   alu_ctrl_t        op;

   // Output slot is free when empty or draining this edge, so a held result
   // blocks input and a MUL can never complete into an occupied slot.
   assign in_ready  = (state_q == ST_IDLE) && (!out_valid_q || bus.out_ready) && !reset;
   assign accept    = bus.in_valid && in_ready;
   assign op        = alu_ctrl_t'(bus.alu_ctrl);
   assign mul_start = accept && (op == ALU_MUL);

   always_comb begin
      case (op)
         ALU_ADD: alu_res = bus.op_a + bus.op_b;
         ALU_SUB: alu_res = bus.op_a - bus.op_b;
         default: alu_res = bus.op_a;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      out_valid_d = out_valid_q;
      result_d    = result_q;
      out_dst_d   = out_dst_q;
      if (out_valid_q && bus.out_ready) begin
         out_valid_d = 1'b0;
      end
      case (state_q)
         ST_IDLE: begin
            if (mul_start) begin
               state_d = ST_MUL_BUSY;
            end else if (accept) begin
               out_valid_d = 1'b1;
               result_d    = alu_res;
               out_dst_d   = bus.dst_reg;
            end
         end
         ST_MUL_BUSY: begin
            if (mul_done) begin
               state_d     = ST_IDLE;
               out_valid_d = 1'b1;
               result_d    = mul_product;
               out_dst_d   = mul_dst;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         out_valid_q <= 1'b0;
         result_q    <= '0;
         out_dst_q   <= '0;
      end else begin
         state_q     <= state_d;
         out_valid_q <= out_valid_d;
         result_q    <= result_d;
         out_dst_q   <= out_dst_d;
      end
   end

   alu_mul_unit #(
      .WIDTH       (WIDTH),
      .MUL_LATENCY (MUL_LATENCY)
   ) u_mul (
      .clk         (clk),
      .reset       (reset),
      .start       (mul_start),
      .active      (state_q == ST_MUL_BUSY),
      .a           (bus.op_a),
      .b           (bus.op_b),
      .dst         (bus.dst_reg),
      .done        (mul_done),
      .product     (mul_product),
      .product_dst (mul_dst)
   );

   assign bus.in_ready    = in_ready;
   assign bus.out_valid   = out_valid_q;
   assign bus.result      = result_q;
   assign bus.out_dst_reg = out_dst_q;
   assign bus.busy        = (state_q == ST_MUL_BUSY);
   assign bus.dbg_state   = state_q;
endmodule

// File: tb/tb_execute_alu.sv
// tb_execute_alu: directed-vector bench for execute_alu (WIDTH=32, MUL_LATENCY=5).
module tb_execute_alu;
   import execute_alu_pkg::*;

   localparam int WIDTH = 32;
   localparam int LAT   = 5;

   logic clk;
   logic reset;

   execute_alu_if #(.WIDTH(WIDTH)) bus ();

   execute_alu #(.WIDTH(WIDTH), .MUL_LATENCY(LAT)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec  = 0;
   int n_miss = 0;
   logic [WIDTH+4:0] exp_q[$];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Offer one operation, wait (bounded) for acceptance, then withdraw it.
   task automatic issue(input logic [1:0] ctrl, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input logic [4:0] dst);
      int n = 0;
      bus.in_valid = 1'b1;
      bus.alu_ctrl = ctrl;
      bus.op_a     = a;
      bus.op_b     = b;
      bus.dst_reg  = dst;
      #1;
      while (!bus.in_ready && n < 50) begin
         step();
         n++;
      end
      if (n >= 50) check("issue_timeout", 64'd0, 64'd1);
      step();
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_out();
      int n = 0;
      while (!bus.out_valid && n < 50) begin
         step();
         n++;
      end
      if (n >= 50) check("out_timeout", 64'd0, 64'd1);
   endtask

   task automatic push(input logic [4:0] dst, input logic [WIDTH-1:0] res);
      exp_q.push_back({dst, res});
   endtask

   // scoreboard: every output transfer must match the next expected entry
   always @(negedge clk) begin
      if (!reset && bus.out_valid && bus.out_ready) begin
         if (exp_q.size() == 0) begin
            check("sb_unexpected", 64'd1, 64'd0);
         end else begin
            logic [WIDTH+4:0] e;
            e = exp_q.pop_front();
            check("sb_result", bus.result, e[WIDTH-1:0]);
            check("sb_dst", bus.out_dst_reg, e[WIDTH+4:WIDTH]);
         end
      end
   end

   initial begin
      logic seen;
      reset         = 1'b1;
      bus.in_valid  = 1'b0;
      bus.alu_ctrl  = 2'b00;
      bus.op_a      = '0;
      bus.op_b      = '0;
      bus.dst_reg   = '0;
      bus.out_ready = 1'b0;
      repeat (3) step();

      check("rst_out_valid", bus.out_valid, 0);
      check("rst_result", bus.result, 0);
      check("rst_dst", bus.out_dst_reg, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_in_ready", bus.in_ready, 0);
      check("rst_state", bus.dbg_state, ST_IDLE);
      reset = 1'b0;
      #1;
      check("idle_in_ready", bus.in_ready, 1);

      // ADD 7+5, one-cycle latency
      bus.out_ready = 1'b1;
      push(5'd3, 32'd12);
      issue(ALU_ADD, 32'd7, 32'd5, 5'd3);
      check("add_valid", bus.out_valid, 1);
      check("add_result", bus.result, 12);
      check("add_dst", bus.out_dst_reg, 3);
      step();
      check("add_drained", bus.out_valid, 0);

      // wraparound, back-to-back
      push(5'd10, 32'hFFFF_FFFF);
      push(5'd11, 32'h0);
      push(5'd2, 32'hDEAD);
      issue(ALU_SUB, 32'd0, 32'd1, 5'd10);
      check("sub_wrap", bus.result, 32'hFFFF_FFFF);
      issue(ALU_ADD, 32'hFFFF_FFFF, 32'd1, 5'd11);
      check("add_wrap", bus.result, 0);
      check("add_wrap_valid", bus.out_valid, 1);
      issue(ALU_PASSA, 32'hDEAD, 32'h1234, 5'd2);
      check("passa", bus.result, 32'hDEAD);
      step();

      // MUL 6*7 with an ADD offered during MUL_BUSY
      push(5'd9, 32'd42);
      push(5'd4, 32'd3);
      issue(ALU_MUL, 32'd6, 32'd7, 5'd9);
      bus.in_valid = 1'b1;
      bus.alu_ctrl = ALU_ADD;
      bus.op_a     = 32'd1;
      bus.op_b     = 32'd2;
      bus.dst_reg  = 5'd4;
      #1;
      for (int i = 0; i < LAT; i++) begin
         check("mul_busy", bus.busy, 1);
         check("mul_in_ready", bus.in_ready, 0);
         check("mul_no_out", bus.out_valid, 0);
         check("mul_state", bus.dbg_state, ST_MUL_BUSY);
         step();
      end
      check("mul_valid", bus.out_valid, 1);
      check("mul_result", bus.result, 42);
      check("mul_dst", bus.out_dst_reg, 9);
      check("mul_busy_end", bus.busy, 0);
      check("mul_in_ready_end", bus.in_ready, 1);
      step();
      check("post_mul_add", bus.result, 3);
      check("post_mul_add_dst", bus.out_dst_reg, 4);
      bus.in_valid = 1'b0;
      step();

      // MUL truncation
      push(5'd1, 32'h0);
      issue(ALU_MUL, 32'h1_0000, 32'h1_0000, 5'd1);
      wait_out();
      check("mul_trunc", bus.result, 0);
      step();

      // backpressure: hold, then release with simultaneous in/out
      push(5'd1, 32'd2);
      push(5'd2, 32'd4);
      push(5'd5, 32'd6);
      issue(ALU_ADD, 32'd1, 32'd1, 5'd1);
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.alu_ctrl  = ALU_ADD;
      bus.op_a      = 32'd2;
      bus.op_b      = 32'd2;
      bus.dst_reg   = 5'd2;
      #1;
      for (int i = 0; i < 3; i++) begin
         check("hold_in_ready", bus.in_ready, 0);
         check("hold_valid", bus.out_valid, 1);
         check("hold_result", bus.result, 2);
         check("hold_dst", bus.out_dst_reg, 1);
         step();
      end
      bus.out_ready = 1'b1;
      #1;
      check("release_in_ready", bus.in_ready, 1);
      step();
      check("swap_valid", bus.out_valid, 1);
      check("swap_result", bus.result, 4);
      bus.op_a    = 32'd3;
      bus.op_b    = 32'd3;
      bus.dst_reg = 5'd5;
      step();
      check("third_result", bus.result, 6);
      bus.in_valid = 1'b0;
      step();
      check("bp_drained", bus.out_valid, 0);
      check("bp_queue_empty", exp_q.size(), 0);

      // reset during MUL cycle 2
      issue(ALU_MUL, 32'd3, 32'd3, 5'd7);
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      #1;
      check("rstmul_in_ready", bus.in_ready, 1);
      check("rstmul_busy", bus.busy, 0);
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         bus.alu_ctrl = 2'($urandom_range(0, 3));
         bus.op_a     = $urandom;
         bus.op_b     = $urandom;
         seen = seen | bus.out_valid;
         step();
      end
      check("rstmul_no_pulse", seen, 0);

      // reset with a held result
      bus.out_ready = 1'b0;
      push(5'd6, 32'd16);
      issue(ALU_ADD, 32'd8, 32'd8, 5'd6);
      check("held_result", bus.result, 16);
      reset = 1'b1;
      exp_q.delete();
      step();
      reset = 1'b0;
      check("rsthold_valid", bus.out_valid, 0);
      check("rsthold_result", bus.result, 0);
      check("rsthold_dst", bus.out_dst_reg, 0);
      bus.out_ready = 1'b1;
      repeat (3) step();
      check("rsthold_no_pulse", bus.out_valid, 0);
      check("final_queue_empty", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule
